// File: rtl/serial_mul_pkg.sv
// rtl/serial_mul_pkg.sv - shared states, default widths and width helper for the serial multiplier
package serial_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int A_W_DEF = 7;
  localparam int B_W_DEF = 6;

  function automatic int prod_w(input int a, input int b);
    return a + b;
  endfunction

endpackage

// File: rtl/serial_pp_multiplier_if.sv
// rtl/serial_pp_multiplier_if.sv - operand/result handshake bundle; out_parity only with SERIAL_MUL_PARITY_EN
interface serial_pp_multiplier_if
  import serial_mul_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int B_W = B_W_DEF
);

  logic                        in_valid;
  logic                        in_ready;
  logic [A_W-1:0]              in_a;
  logic [B_W-1:0]              in_b;
  logic                        out_valid;
  logic                        out_ready;
  logic [prod_w(A_W,B_W)-1:0]  out_prod;
`ifdef SERIAL_MUL_PARITY_EN
  logic                        out_parity;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod, out_parity
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod, out_parity
  );
`else
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod
  );
`endif

endinterface

// File: rtl/serial_pp_multiplier_pp_accum_step.sv
// rtl/serial_pp_multiplier_pp_accum_step.sv - one shift-and-add iteration: conditional add, then shift both operands
module pp_accum_step #(
  parameter int P_W = 13,
  parameter int B_W = 6
) (
  input  logic [P_W-1:0] acc,
  input  logic [P_W-1:0] mcand,
  input  logic [B_W-1:0] mplier,
  output logic [P_W-1:0] acc_nxt,
  output logic [P_W-1:0] mcand_nxt,
  output logic [B_W-1:0] mplier_nxt
);

  // acc cannot overflow: the full product always fits in P_W bits
  assign acc_nxt    = mplier[0] ? acc + mcand : acc;
  assign mcand_nxt  = mcand << 1;
  assign mplier_nxt = mplier >> 1;

endmodule

// File: rtl/serial_pp_multiplier.sv
// rtl/serial_pp_multiplier.sv - sequential shift-and-add multiplier, one multiplier bit per cycle; SERIAL_MUL_PARITY_EN adds out_parity
module serial_pp_multiplier
  import serial_mul_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int B_W = B_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_pp_multiplier_if.slave bus
);

  localparam int P_W  = prod_w(A_W, B_W);
  localparam int CW   = $clog2(B_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(B_W - 1);

  state_t          state;
  logic [P_W-1:0]  acc;
  logic [P_W-1:0]  mcand;
  logic [B_W-1:0]  mplier;
  logic [CW-1:0]   cnt;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [P_W-1:0]  out_prod_q;

  logic [P_W-1:0]  acc_nxt;
  logic [P_W-1:0]  mcand_nxt;
  logic [B_W-1:0]  mplier_nxt;

  pp_accum_step #(.P_W(P_W), .B_W(B_W)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .acc_nxt    (acc_nxt),
    .mcand_nxt  (mcand_nxt),
    .mplier_nxt (mplier_nxt)
  );

`ifdef SERIAL_MUL_PARITY_EN
  logic parity_q;
  assign bus.out_parity = parity_q;
`endif

  // Outputs are loaded from acc_nxt on the last MUL edge so out_valid and the
  // final product appear together, B_W edges after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_prod_q  <= '0;
`ifdef SERIAL_MUL_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand      <= P_W'(bus.in_a);
            mplier     <= bus.in_b;
            acc        <= '0;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= MUL;
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand_nxt;
          mplier <= mplier_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            out_valid_q <= 1'b1;
            out_prod_q  <= acc_nxt;
`ifdef SERIAL_MUL_PARITY_EN
            parity_q    <= ^acc_nxt;
`endif
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_prod  = out_prod_q;

endmodule
